// File: rtl/fip_pkg.sv
// Shared helpers for the fixed-point 3x3 determinant pipeline:
// intermediate width rules, signed range bounds and result narrowing.
package fip_pkg;

  localparam int FIP_MAX_W = 64;
  localparam int FIP_WIDE  = 3 * FIP_MAX_W + 3;

  typedef logic signed [FIP_WIDE-1:0] fip_wide_t;

  typedef struct packed {
    logic                 ovf;
    logic [FIP_MAX_W-1:0] val;
  } fip_narrow_t;

  // Exact widths: a 2x2 minor of W-bit elements, and the full cofactor sum.
  function automatic int fip_minor_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int fip_raw_w(input int w);
    return 3 * w + 3;
  endfunction

  function automatic fip_wide_t fip_min(input int w);
    fip_wide_t m;
    m = '1;
    return m <<< (w - 1);
  endfunction

  function automatic fip_wide_t fip_max(input int w);
    return ~fip_min(w);
  endfunction

  // Caller keeps the low w bits of val; ovf reports the exact value left the range.
  function automatic fip_narrow_t fip_narrow(input fip_wide_t value, input int w, input bit sat);
    fip_narrow_t r;
    fip_wide_t   lo;
    fip_wide_t   hi;
    fip_wide_t   c;
    lo    = fip_min(w);
    hi    = fip_max(w);
    r.ovf = (value < lo) || (value > hi);
    c     = value;
    if (sat && (value < lo)) c = lo;
    else if (sat && (value > hi)) c = hi;
    r.val = c[FIP_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fip_pipe_stage.sv
// Generic valid/ready register slice; one cycle latency, accepts whenever empty
// or when the downstream takes the current word in the same cycle.
module fip_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fip_det3_pipe.sv
// Pipelined signed fixed-point 3x3 determinant: three register stages, one matrix per cycle,
// exact intermediates with a single floor at the end; stalls hold the output and fill bubbles.
module fip_det3_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRA_BITS = 16,
  parameter int SAT      = 1,
  parameter int TAG_W    = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [2:0][2:0][WIDTH-1:0]  i_mat,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [WIDTH-1:0]            o_det,
  output logic [TAG_W-1:0]            o_tag,
  output logic                        o_ovf
);
  import fip_pkg::*;

  localparam int PW = 2 * WIDTH;
  localparam int MW = fip_minor_w(WIDTH);
  localparam int RW = fip_raw_w(WIDTH);

  typedef struct packed {
    logic [TAG_W-1:0]           tag;
    logic [2:0][2:0][WIDTH-1:0] mat;
  } s0_t;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [2:0][WIDTH-1:0] row0;
    logic [2:0][MW-1:0]    minor;
  } s1_t;

  typedef struct packed {
    logic             ovf;
    logic [WIDTH-1:0] det;
    logic [TAG_W-1:0] tag;
  } s2_t;

  s0_t  s0_in, s0_q;
  s1_t  s1_in, s1_q;
  s2_t  s2_in, s2_q;
  logic s0_vld, s1_vld;
  logic s1_rdy, s2_rdy;

  assign s0_in = '{tag: i_tag, mat: i_mat};

  fip_pipe_stage #(.DATA_W($bits(s0_t))) u_s0 (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .in_valid_i  (i_valid),
    .in_ready_o  (o_ready),
    .in_data_i   (s0_in),
    .out_valid_o (s0_vld),
    .out_ready_i (s1_rdy),
    .out_data_o  (s0_q)
  );

  // Rows 1 and 2 (d e f / g h i) form the three cofactor minors.
  logic signed [PW-1:0] d_x, e_x, f_x, g_x, h_x, i_x;
  logic signed [PW-1:0] p_ei, p_fh, p_fg, p_di, p_dh, p_eg;

  assign d_x = PW'($signed(s0_q.mat[1][0]));
  assign e_x = PW'($signed(s0_q.mat[1][1]));
  assign f_x = PW'($signed(s0_q.mat[1][2]));
  assign g_x = PW'($signed(s0_q.mat[2][0]));
  assign h_x = PW'($signed(s0_q.mat[2][1]));
  assign i_x = PW'($signed(s0_q.mat[2][2]));

  assign p_ei = e_x * i_x;
  assign p_fh = f_x * h_x;
  assign p_fg = f_x * g_x;
  assign p_di = d_x * i_x;
  assign p_dh = d_x * h_x;
  assign p_eg = e_x * g_x;

  always_comb begin
    s1_in.tag      = s0_q.tag;
    s1_in.row0     = s0_q.mat[0];
    s1_in.minor[0] = MW'(p_ei) - MW'(p_fh);
    s1_in.minor[1] = MW'(p_fg) - MW'(p_di);
    s1_in.minor[2] = MW'(p_dh) - MW'(p_eg);
  end

  fip_pipe_stage #(.DATA_W($bits(s1_t))) u_s1 (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .in_valid_i  (s0_vld),
    .in_ready_o  (s1_rdy),
    .in_data_i   (s1_in),
    .out_valid_o (s1_vld),
    .out_ready_i (s2_rdy),
    .out_data_o  (s1_q)
  );

  logic signed [RW-1:0] a_x, b_x, c_x, m0_x, m1_x, m2_x;
  logic signed [RW-1:0] raw, q;
  fip_narrow_t          nar;
  logic                 unused_narrow;

  assign a_x  = RW'($signed(s1_q.row0[0]));
  assign b_x  = RW'($signed(s1_q.row0[1]));
  assign c_x  = RW'($signed(s1_q.row0[2]));
  assign m0_x = RW'($signed(s1_q.minor[0]));
  assign m1_x = RW'($signed(s1_q.minor[1]));
  assign m2_x = RW'($signed(s1_q.minor[2]));

  // raw carries scale 2^(3F); the arithmetic shift floors back to scale 2^F.
  assign raw = a_x * m0_x + b_x * m1_x + c_x * m2_x;
  assign q   = raw >>> (2 * FRA_BITS);
  assign nar = fip_narrow(FIP_WIDE'(q), WIDTH, SAT != 0);
  assign unused_narrow = ^nar.val;

  assign s2_in = '{ovf: nar.ovf, det: nar.val[WIDTH-1:0], tag: s1_q.tag};

  fip_pipe_stage #(.DATA_W($bits(s2_t))) u_s2 (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .in_valid_i  (s1_vld),
    .in_ready_o  (s2_rdy),
    .in_data_i   (s2_in),
    .out_valid_o (o_valid),
    .out_ready_i (i_ready),
    .out_data_o  (s2_q)
  );

  assign o_det = s2_q.det;
  assign o_tag = s2_q.tag;
  assign o_ovf = s2_q.ovf;

endmodule

// File: tb/tb_fip_det3_pipe.sv
// Bench for fip_det3_pipe: saturating and wrapping instances driven in parallel against a 128-bit cofactor model.
module tb_fip_det3_pipe;

  typedef logic [2:0][2:0][31:0] mat_t;
  typedef struct packed {
    logic [31:0] det;
    logic        ovf;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_vld;
  logic        rdy_in;
  mat_t        mat;
  logic [7:0]  tag;
  logic        s_ordy, s_ovld, s_ovf, w_ordy, w_ovld, w_ovf;
  logic [31:0] s_det, w_det;
  logic [7:0]  s_tag, w_tag;

  int   total = 0;
  int   bad   = 0;
  int   n_out_s = 0;
  exp_t qs[$];
  exp_t qw[$];

  always #5 clk = ~clk;

  fip_det3_pipe #(.WIDTH(32), .FRA_BITS(16), .SAT(1), .TAG_W(8)) dut_s (
    .i_clk(clk), .i_rstn(rstn), .i_valid(in_vld), .o_ready(s_ordy), .i_mat(mat), .i_tag(tag),
    .o_valid(s_ovld), .i_ready(rdy_in), .o_det(s_det), .o_tag(s_tag), .o_ovf(s_ovf)
  );

  fip_det3_pipe #(.WIDTH(32), .FRA_BITS(16), .SAT(0), .TAG_W(8)) dut_w (
    .i_clk(clk), .i_rstn(rstn), .i_valid(in_vld), .o_ready(w_ordy), .i_mat(mat), .i_tag(tag),
    .o_valid(w_ovld), .i_ready(rdy_in), .o_det(w_det), .o_tag(w_tag), .o_ovf(w_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Exact determinant by cofactor expansion, floored to Q16.16, then saturated or wrapped.
  function automatic void model(input mat_t m, input bit sat, output logic [31:0] det, output logic ovf);
    logic signed [127:0] x [3][3];
    logic signed [127:0] dt;
    logic signed [127:0] q;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        x[r][c] = 128'($signed(m[r][c]));
    dt = x[0][0] * (x[1][1] * x[2][2] - x[1][2] * x[2][1])
       - x[0][1] * (x[1][0] * x[2][2] - x[1][2] * x[2][0])
       + x[0][2] * (x[1][0] * x[2][1] - x[1][1] * x[2][0]);
    q   = dt >>> 32;
    ovf = (q > 128'sd2147483647) || (q < -128'sd2147483648);
    if (sat && ovf) det = (q < 0) ? 32'h80000000 : 32'h7FFFFFFF;
    else            det = q[31:0];
  endfunction

  function automatic mat_t diag(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    mat_t m;
    m = '0;
    m[0][0] = x;
    m[1][1] = y;
    m[2][2] = z;
    return m;
  endfunction

  function automatic mat_t rows(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input logic [31:0] d, input logic [31:0] e, input logic [31:0] f,
                                input logic [31:0] g, input logic [31:0] h, input logic [31:0] i);
    mat_t m;
    m[0][0] = a; m[0][1] = b; m[0][2] = c;
    m[1][0] = d; m[1][1] = e; m[1][2] = f;
    m[2][0] = g; m[2][1] = h; m[2][2] = i;
    return m;
  endfunction

  // Scoreboard: one check per cycle the outputs are meaningful, expectations queued at acceptance.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] d;
    logic        o;
    if (!rstn) begin
      qs.delete();
      qw.delete();
    end else begin
      if (s_ovld) begin
        if (qs.size() == 0) chk1("s_unexpected_valid", s_ovld, 1'b0);
        else begin
          e = qs[0];
          chk("s_det", s_det, e.det);
          chk1("s_ovf", s_ovf, e.ovf);
          chk("s_tag", 32'(s_tag), 32'(e.tag));
          if (rdy_in) begin
            void'(qs.pop_front());
            n_out_s++;
          end
        end
      end
      if (w_ovld) begin
        if (qw.size() == 0) chk1("w_unexpected_valid", w_ovld, 1'b0);
        else begin
          e = qw[0];
          chk("w_det", w_det, e.det);
          chk1("w_ovf", w_ovf, e.ovf);
          chk("w_tag", 32'(w_tag), 32'(e.tag));
          if (rdy_in) void'(qw.pop_front());
        end
      end
      if (in_vld && s_ordy) begin
        model(mat, 1'b1, d, o);
        qs.push_back('{det: d, ovf: o, tag: tag});
      end
      if (in_vld && w_ordy) begin
        model(mat, 1'b0, d, o);
        qw.push_back('{det: d, ovf: o, tag: tag});
      end
    end
  end

  task automatic send(input mat_t m, input logic [7:0] t);
    bit acc;
    acc    = 1'b0;
    in_vld = 1'b1;
    mat    = m;
    tag    = t;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = s_ordy;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk1("send_accept_timeout", acc, 1'b1);
  endtask

  task automatic expect_out(input string nm, input logic [31:0] ds, input logic [31:0] dw, input logic ov);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = s_ovld;
    end
    chk1({nm, "_seen"}, seen, 1'b1);
    if (seen) begin
      chk({nm, "_sat"}, s_det, ds);
      chk({nm, "_wrap"}, w_det, dw);
      chk1({nm, "_ovf_s"}, s_ovf, ov);
      chk1({nm, "_ovf_w"}, w_ovf, ov);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        o;
    int          n0;

    // Hand-computed pins on the model itself.
    model(diag(32'h00640000, 32'h00640000, 32'h00640000), 1'b1, d, o);
    chk("model_big_sat", d, 32'h7FFFFFFF);
    chk1("model_big_ovf", o, 1'b1);
    model(diag(32'h00640000, 32'h00640000, 32'h00640000), 1'b0, d, o);
    chk("model_big_wrap", d, 32'h42400000);
    model(diag(32'hFFFFFFFF, 32'h00000001, 32'h00010000), 1'b1, d, o);
    chk("model_floor", d, 32'hFFFFFFFF);
    model(diag(32'hFF9C0000, 32'h00640000, 32'h00640000), 1'b0, d, o);
    chk("model_neg_wrap", d, 32'hBDC00000);

    rstn   = 1'b0;
    in_vld = 1'b0;
    rdy_in = 1'b1;
    mat    = '0;
    tag    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ovalid", s_ovld, 1'b0);
    chk("rst_det", s_det, 32'h0);
    chk("rst_tag", 32'(s_tag), 32'h0);
    chk1("rst_ovf", s_ovf, 1'b0);
    chk1("rst_oready", s_ordy, 1'b1);
    chk1("rst_ovalid_w", w_ovld, 1'b0);
    rstn = 1'b1;

    // Identity: result three edges after it is presented.
    send(diag(32'h00010000, 32'h00010000, 32'h00010000), 8'h5A);
    in_vld = 1'b0;
    @(posedge clk); #1;
    chk1("id_not_early", s_ovld, 1'b0);
    @(posedge clk); #1;
    chk1("id_valid", s_ovld, 1'b1);
    chk("id_det", s_det, 32'h00010000);
    chk("id_tag", 32'(s_tag), 32'h5A);
    chk1("id_ovf", s_ovf, 1'b0);

    // Back-to-back: one result per cycle.
    send(diag(32'h00020000, 32'h00030000, 32'h00040000), 8'h01);
    send(rows(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000,
              32'h00060000, 32'h00070000, 32'h00080000, 32'h00090000), 8'h02);
    in_vld = 1'b0;
    @(posedge clk); #1;
    chk1("b2b_first_valid", s_ovld, 1'b1);
    chk("b2b_first_det", s_det, 32'h00180000);
    @(posedge clk); #1;
    chk1("b2b_second_valid", s_ovld, 1'b1);
    chk("b2b_second_det", s_det, 32'h00000000);
    chk("b2b_second_tag", 32'(s_tag), 32'h02);

    send(diag(32'h00640000, 32'h00640000, 32'h00640000), 8'h30); in_vld = 1'b0;
    expect_out("ovf_pos", 32'h7FFFFFFF, 32'h42400000, 1'b1);
    send(diag(32'hFF9C0000, 32'h00640000, 32'h00640000), 8'h31); in_vld = 1'b0;
    expect_out("ovf_neg", 32'h80000000, 32'hBDC00000, 1'b1);
    send(diag(32'h00008000, 32'h00008000, 32'h00008000), 8'h32); in_vld = 1'b0;
    expect_out("half", 32'h00002000, 32'h00002000, 1'b0);
    send(diag(32'hFFFFFFFF, 32'h00000001, 32'h00010000), 8'h33); in_vld = 1'b0;
    expect_out("floor_neg", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send(diag(32'h00000001, 32'h00000001, 32'h00000001), 8'h34); in_vld = 1'b0;
    expect_out("floor_pos", 32'h00000000, 32'h00000000, 1'b0);

    // General matrices, checked by the scoreboard only.
    send(rows(32'h00018000, 32'hFFFE0000, 32'h00004000, 32'h00030000, 32'h00008000,
              32'hFFFF0000, 32'h00020000, 32'h00010000, 32'h00040000), 8'h40);
    send(rows(32'hFFF6A000, 32'h0003C000, 32'h00001234, 32'h7FFF0000, 32'h80010000,
              32'h00050000, 32'h000A0000, 32'hFFFFC000, 32'h00123456), 8'h41);
    send(rows(32'h00000003, 32'hFFFFFFFD, 32'h00000007, 32'h00011111, 32'hFFFEEEEF,
              32'h00000100, 32'h00002000, 32'h00000000, 32'hFFFFF000), 8'h42);
    in_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Backpressure: output stalled for 8 cycles while 6 matrices stream in.
    n0 = n_out_s;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(diag(32'(k + 1) << 16, 32'h00010000, 32'h00010000), 8'h10 + 8'(k));
        in_vld = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        rdy_in = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk1("bp_oready_low", s_ordy, 1'b0);
        chk1("bp_ovalid_held", s_ovld, 1'b1);
        @(posedge clk);
        #1;
        rdy_in = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("bp_out_count", 32'(n_out_s - n0), 32'd6);

    // Reset with three matrices in flight.
    send(diag(32'h00020000, 32'h00030000, 32'h00040000), 8'h21);
    send(diag(32'h00030000, 32'h00030000, 32'h00030000), 8'h22);
    send(diag(32'h00050000, 32'h00010000, 32'h00010000), 8'h23);
    in_vld = 1'b0;
    rstn   = 1'b0;
    @(posedge clk); #1;
    chk1("mrst_ovalid", s_ovld, 1'b0);
    chk("mrst_det", s_det, 32'h0);
    chk("mrst_tag", 32'(s_tag), 32'h0);
    chk1("mrst_ovf", s_ovf, 1'b0);
    chk1("mrst_oready", s_ordy, 1'b1);
    chk1("mrst_ovalid_w", w_ovld, 1'b0);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("final_queue_s", 32'(qs.size()), 32'd0);
    chk("final_queue_w", 32'(qw.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
